// File: rtl/ramb_fifo_pkg.sv
// Shared constants and types for the RAMB16_S2_S4 width-converting FIFO.
// Symbols are 2 bits on the write side; words are 4 bits on the read side.
package ramb_fifo_pkg;

  localparam int DEPTH_SYM  = 8192;
  localparam int DEPTH_WORD = 4096;
  localparam int WR_PTR_W   = 14;
  localparam int RD_PTR_W   = 13;

  typedef logic [1:0]          sym_t;
  typedef logic [3:0]          word_t;
  typedef logic [WR_PTR_W-1:0] wr_ptr_t;
  typedef logic [RD_PTR_W-1:0] rd_ptr_t;

endpackage

// File: rtl/ramb_s2_s4_fifo_ctrl.sv
// 2-bit in / 4-bit out FWFT FIFO controller driving an external RAMB16_S2_S4.
// Optional RAMB_FIFO_FLUSH_EN adds a synchronous FLUSH input.
module ramb_s2_s4_fifo_ctrl
  import ramb_fifo_pkg::*;
#(
  parameter int AFULL_THRESH = 8064
) (
  input  logic        CLK,
  input  logic        RST_N,
`ifdef RAMB_FIFO_FLUSH_EN
  input  logic        FLUSH,
`endif
  input  sym_t        S_DATA,
  input  logic        S_VALID,
  output logic        S_READY,
  output word_t       M_DATA,
  output logic        M_VALID,
  input  logic        M_READY,
  output logic        AFULL,
  output logic [12:0] ADDRA,
  output sym_t        DIA,
  output logic        ENA,
  output logic        WEA,
  output logic        SSRA,
  output logic        SSRB,
  output logic        WEB,
  output word_t       DIB,
  output logic [$clog2(DEPTH_WORD)-1:0] ADDRB,
  output logic        ENB,
  input  word_t       DOB
);

  wr_ptr_t wr_ptr;
  rd_ptr_t rd_ptr;
  wr_ptr_t level;
  logic    m_valid;
  logic    flush;
  logic    wr_fire;
  logic    rd_issue;

`ifdef RAMB_FIFO_FLUSH_EN
  assign flush = FLUSH;
`else
  assign flush = 1'b0;
`endif

  // Level in symbols; a word moved into DOB no longer counts.
  assign level = wr_ptr - {rd_ptr, 1'b0};

  assign S_READY = level < wr_ptr_t'(DEPTH_SYM);
  assign AFULL   = 32'(level) >= 32'(AFULL_THRESH);

  // Reset gating keeps the RAM enables low while RST_N is held.
  assign wr_fire  = S_VALID & S_READY & RST_N & ~flush;
  assign rd_issue = (level >= wr_ptr_t'(2))
                  & (~m_valid | M_READY)
                  & RST_N & ~flush;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      m_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      m_valid <= 1'b0;
    end else begin
      if (wr_fire)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_issue)
        rd_ptr <= rd_ptr + 1'b1;
      m_valid <= rd_issue | (m_valid & ~M_READY);
    end
  end

  assign ADDRA = wr_ptr[12:0];
  assign DIA   = S_DATA;
  assign ENA   = wr_fire;
  assign WEA   = wr_fire;

  assign ADDRB = rd_ptr[11:0];
  assign ENB   = rd_issue;
  assign DIB   = '0;
  assign WEB   = 1'b0;
  assign SSRA  = 1'b0;
  assign SSRB  = 1'b0;

  // DOB is held by the RAM while ENB is low, so it is the output register.
  assign M_DATA  = DOB;
  assign M_VALID = m_valid;

endmodule

// File: tb/tb_ramb_s2_s4_fifo_ctrl.sv
// Directed bench for ramb_s2_s4_fifo_ctrl with a behavioural RAMB16_S2_S4.
// Define RAMB_FIFO_FLUSH_EN to also exercise FLUSH.
module tb_ramb_s2_s4_fifo_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [1:0]  S_DATA = '0;
  logic        S_VALID = 1'b0;
  logic        S_READY;
  logic [3:0]  M_DATA;
  logic        M_VALID;
  logic        M_READY = 1'b0;
  logic        AFULL;
  logic [12:0] ADDRA;
  logic [1:0]  DIA;
  logic        ENA, WEA, SSRA, SSRB, WEB;
  logic [3:0]  DIB;
  logic [11:0] ADDRB;
  logic        ENB;
  logic [3:0]  DOB = '0;
`ifdef RAMB_FIFO_FLUSH_EN
  logic        FLUSH = 1'b0;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  logic [1:0] mem [0:8191];

  always #5 CLK = ~CLK;

  // Port A: 8192 x 2 write; port B: 4096 x 4 registered read.
  always @(posedge CLK) begin
    if (ENA && WEA) mem[ADDRA] <= DIA;
    if (ENB) DOB <= {mem[{ADDRB, 1'b1}], mem[{ADDRB, 1'b0}]};
  end

  ramb_s2_s4_fifo_ctrl dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
`ifdef RAMB_FIFO_FLUSH_EN
    .FLUSH   (FLUSH),
`endif
    .S_DATA  (S_DATA),
    .S_VALID (S_VALID),
    .S_READY (S_READY),
    .M_DATA  (M_DATA),
    .M_VALID (M_VALID),
    .M_READY (M_READY),
    .AFULL   (AFULL),
    .ADDRA   (ADDRA),
    .DIA     (DIA),
    .ENA     (ENA),
    .WEA     (WEA),
    .SSRA    (SSRA),
    .SSRB    (SSRB),
    .WEB     (WEB),
    .DIB     (DIB),
    .ADDRB   (ADDRB),
    .ENB     (ENB),
    .DOB     (DOB)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_chk++;
    if ({S_READY, M_VALID, AFULL, ENA, WEA, ENB} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 100000",
               {S_READY, M_VALID, AFULL, ENA, WEA, ENB});
    end
    n_chk++;
    if ({ADDRA, ADDRB} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_addr: got %h/%h want 0/0", ADDRA, ADDRB);
    end
    n_chk++;
    if ({SSRA, SSRB, WEB, DIB} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_const: got %b want 0", {SSRA, SSRB, WEB, DIB});
    end
    RST_N = 1'b1;
    tick();
  endtask

  task automatic test_ordering();
    M_READY = 1'b1;
    S_VALID = 1'b1;
    S_DATA = 2'd1; tick();
    S_DATA = 2'd2; tick();
    S_DATA = 2'd3; tick();
    n_chk++;
    if ({M_VALID, M_DATA} !== 5'b1_1001) begin
      n_fail++;
      $display("FAIL order_w0: got %b want 1_1001", {M_VALID, M_DATA});
    end
    S_DATA = 2'd0; tick();
    n_chk++;
    if (M_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL order_gap: got %b want 0", M_VALID);
    end
    S_VALID = 1'b0; tick();
    n_chk++;
    if ({M_VALID, M_DATA} !== 5'b1_0011) begin
      n_fail++;
      $display("FAIL order_w1: got %b want 1_0011", {M_VALID, M_DATA});
    end
    tick();
    n_chk++;
    if (M_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL order_end: got %b want 0", M_VALID);
    end
  endtask

  task automatic test_odd_tail();
    int         cnt = 0;
    logic [3:0] got = '0;
    M_READY = 1'b1;
    S_VALID = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i == 0) S_DATA = 2'd2;
      if (i == 1) S_DATA = 2'd1;
      if (i == 2) S_DATA = 2'd3;
      if (i == 3) S_VALID = 1'b0;
      tick();
      if (M_VALID) begin
        cnt++;
        got = M_DATA;
      end
    end
    n_chk++;
    if (cnt != 1 || got !== 4'b0110) begin
      n_fail++;
      $display("FAIL tail_one_word: got %0d/%b want 1/0110", cnt, got);
    end
    n_chk++;
    if (M_VALID !== 1'b0 || S_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL tail_idle: got %b%b want 01", M_VALID, S_READY);
    end
    cnt = 0;
    S_VALID = 1'b1;
    S_DATA = 2'd0;
    tick();
    S_VALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (M_VALID) begin
        cnt++;
        got = M_DATA;
      end
    end
    n_chk++;
    if (cnt != 1 || got !== 4'b0011) begin
      n_fail++;
      $display("FAIL tail_partner: got %0d/%b want 1/0011", cnt, got);
    end
  endtask

  task automatic test_hold();
    int bad = 0;
    M_READY = 1'b0;
    S_VALID = 1'b1;
    S_DATA = 2'd3; tick();
    S_DATA = 2'd0; tick();
    S_DATA = 2'd1; tick();
    S_DATA = 2'd1; tick();
    S_DATA = 2'd2; tick();
    S_DATA = 2'd3; tick();
    S_VALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if ({M_VALID, ENB, M_DATA} !== 6'b10_0011) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hold_stable: got %0d bad cycles want 0", bad);
    end
    M_READY = 1'b1;
    #1;
    n_chk++;
    if (ENB !== 1'b1 || ADDRB !== 12'd5) begin
      n_fail++;
      $display("FAIL hold_release_issue: got %b/%0d want 1/5", ENB, ADDRB);
    end
    tick();
    n_chk++;
    if ({M_VALID, M_DATA} !== 5'b1_0101) begin
      n_fail++;
      $display("FAIL hold_next_w1: got %b want 1_0101", {M_VALID, M_DATA});
    end
    tick();
    n_chk++;
    if ({M_VALID, M_DATA} !== 5'b1_1110) begin
      n_fail++;
      $display("FAIL hold_next_w2: got %b want 1_1110", {M_VALID, M_DATA});
    end
    tick();
    n_chk++;
    if (M_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_drained: got %b want 0", M_VALID);
    end
    M_READY = 1'b0;
  endtask

  // The first word moves into DOB, so 8192 in RAM + 2 held = 8194 accepted.
  task automatic test_full();
    logic [1:0] syms [$];
    int         acc = 0;
    int         afull_at = -1;
    int         ready_fall = -1;
    int         idx = 1;
    int         bad = 0;
    M_READY = 1'b0;
    S_VALID = 1'b1;
    for (int i = 0; i < 9000 && ready_fall < 0; i++) begin
      S_DATA = 2'(acc ^ (acc >> 2));
      if (S_READY) begin
        syms.push_back(S_DATA);
        acc++;
      end
      tick();
      if (AFULL && afull_at < 0) afull_at = acc;
      if (!S_READY && ready_fall < 0) ready_fall = acc;
    end
    n_chk++;
    if (afull_at != 8066) begin
      n_fail++;
      $display("FAIL full_afull_rise: got %0d want 8066", afull_at);
    end
    n_chk++;
    if (ready_fall != 8194) begin
      n_fail++;
      $display("FAIL full_ready_fall: got %0d want 8194", ready_fall);
    end
    if (syms.size() < 8194) begin
      n_chk++;
      n_fail++;
      $display("FAIL full_fill: got %0d want 8194", syms.size());
      S_VALID = 1'b0;
      return;
    end
    tick();
    n_chk++;
    if (S_READY !== 1'b0 || ENA !== 1'b0 || AFULL !== 1'b1) begin
      n_fail++;
      $display("FAIL full_stays: got %b%b%b want 001", S_READY, ENA, AFULL);
    end
    S_VALID = 1'b0;
    M_READY = 1'b1;
    #1;
    n_chk++;
    if ({ENB, M_VALID, M_DATA} !== {2'b11, syms[1], syms[0]}) begin
      n_fail++;
      $display("FAIL full_word0: got %b want %b",
               {ENB, M_VALID, M_DATA}, {2'b11, syms[1], syms[0]});
    end
    tick();
    M_READY = 1'b0;
    n_chk++;
    if (S_READY !== 1'b1) begin
      n_fail++;
      $display("FAIL full_recover: got %b want 1", S_READY);
    end
    M_READY = 1'b1;
    for (int c = 0; c < 5000 && idx < 4097; c++) begin
      if (M_VALID) begin
        if (M_DATA !== {syms[2*idx+1], syms[2*idx]}) bad++;
        idx++;
      end
      tick();
    end
    n_chk++;
    if (idx != 4097 || bad != 0) begin
      n_fail++;
      $display("FAIL full_drain: got %0d words %0d bad want 4097 0", idx, bad);
    end
    n_chk++;
    if (M_VALID !== 1'b0 || AFULL !== 1'b0) begin
      n_fail++;
      $display("FAIL full_empty: got %b%b want 00", M_VALID, AFULL);
    end
    M_READY = 1'b0;
  endtask

  task automatic test_async_reset();
    M_READY = 1'b0;
    S_VALID = 1'b1;
    for (int i = 0; i < 6; i++) begin
      S_DATA = 2'(i + 1);
      tick();
    end
    n_chk++;
    if (M_VALID !== 1'b1 || ADDRA === 13'd0) begin
      n_fail++;
      $display("FAIL arst_pre: got %b/%0d want 1/nonzero", M_VALID, ADDRA);
    end
    #3;
    RST_N = 1'b0;
    #1;
    n_chk++;
    if ({S_READY, M_VALID, AFULL, ENA, WEA, ENB} !== 6'b100000) begin
      n_fail++;
      $display("FAIL arst_flags: got %b want 100000",
               {S_READY, M_VALID, AFULL, ENA, WEA, ENB});
    end
    n_chk++;
    if ({ADDRA, ADDRB} !== 25'd0) begin
      n_fail++;
      $display("FAIL arst_addr: got %h/%h want 0/0", ADDRA, ADDRB);
    end
    S_VALID = 1'b0;
    tick();
    RST_N = 1'b1;
    M_READY = 1'b1;
    S_VALID = 1'b1;
    S_DATA = 2'd2;
    #1;
    n_chk++;
    if (ADDRA !== 13'd0 || ENA !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_first_addr: got %0d/%b want 0/1", ADDRA, ENA);
    end
    tick();
    S_DATA = 2'd3; tick();
    S_DATA = 2'd1; tick();
    n_chk++;
    if ({M_VALID, M_DATA} !== 5'b1_1110) begin
      n_fail++;
      $display("FAIL arst_w0: got %b want 1_1110", {M_VALID, M_DATA});
    end
    S_DATA = 2'd0; tick();
    S_VALID = 1'b0; tick();
    n_chk++;
    if ({M_VALID, M_DATA} !== 5'b1_0001) begin
      n_fail++;
      $display("FAIL arst_w1: got %b want 1_0001", {M_VALID, M_DATA});
    end
    tick();
    M_READY = 1'b0;
  endtask

`ifdef RAMB_FIFO_FLUSH_EN
  task automatic test_flush();
    int         cnt = 0;
    logic [3:0] got = '0;
    M_READY = 1'b0;
    S_VALID = 1'b1;
    for (int i = 0; i < 10; i++) begin
      S_DATA = 2'(i);
      tick();
    end
    S_DATA = 2'd2;
    FLUSH = 1'b1;
    #1;
    n_chk++;
    if ({ENA, WEA, ENB} !== 3'b000) begin
      n_fail++;
      $display("FAIL flush_enables: got %b want 000", {ENA, WEA, ENB});
    end
    tick();
    FLUSH = 1'b0;
    S_VALID = 1'b0;
    n_chk++;
    if ({M_VALID, S_READY, AFULL} !== 3'b010 || ADDRA !== 13'd0) begin
      n_fail++;
      $display("FAIL flush_state: got %b/%0d want 010/0",
               {M_VALID, S_READY, AFULL}, ADDRA);
    end
    M_READY = 1'b1;
    S_VALID = 1'b1;
    S_DATA = 2'd3; tick();
    S_DATA = 2'd1; tick();
    S_VALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (M_VALID) begin
        cnt++;
        got = M_DATA;
      end
    end
    n_chk++;
    if (cnt != 1 || got !== 4'b0111) begin
      n_fail++;
      $display("FAIL flush_refill: got %0d/%b want 1/0111", cnt, got);
    end
    M_READY = 1'b0;
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ordering();
    test_odd_tail();
    test_hold();
    test_full();
    test_async_reset();
`ifdef RAMB_FIFO_FLUSH_EN
    test_flush();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
